// File: rtl/mesh_term_pkg.sv
// Shared types and sizing helpers for the mesh terminal buffering bank.
package mesh_term_pkg;

    localparam int unsigned PCKG_SZ_DEF = 40;
    localparam int unsigned CNT_W_DEF   = 16;

    typedef logic [PCKG_SZ_DEF-1:0] pkt_t;
    typedef logic [CNT_W_DEF-1:0]   cnt_t;

    // One terminal on every edge position of the ROWS x COLUMS mesh.
    function automatic int unsigned n_term(input int unsigned rows, input int unsigned cols);
        return 2 * rows + 2 * cols;
    endfunction

endpackage

// File: rtl/mesh_term_fifo.sv
// Synchronous first-word-fall-through FIFO; head and flags come straight from state.
module mesh_term_fifo #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is taken only when the head leaves on the same edge.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/mesh_term_fifo_bank.sv
// Per-terminal TX/RX buffering between drivers, the mesh and monitors, with statistics.
module mesh_term_fifo_bank
    import mesh_term_pkg::*;
#(
    parameter  int unsigned ROWS       = 4,
    parameter  int unsigned COLUMS     = 4,
    parameter  int unsigned PCKG_SZ    = PCKG_SZ_DEF,
    parameter  int unsigned FIFO_DEPTH = 4,
    parameter  int unsigned CNT_W      = CNT_W_DEF,
    localparam int unsigned N_TERM     = n_term(ROWS, COLUMS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_TERM-1:0]           drv_push,
    input  logic [N_TERM*PCKG_SZ-1:0]   drv_data,
    output logic [N_TERM-1:0]           drv_full,
    output logic [N_TERM-1:0]           pndng_i_in,
    output logic [N_TERM*PCKG_SZ-1:0]   data_out_i_in,
    input  logic [N_TERM-1:0]           popin,
    input  logic [N_TERM-1:0]           pndng,
    input  logic [N_TERM*PCKG_SZ-1:0]   data_out,
    output logic [N_TERM-1:0]           pop,
    output logic [N_TERM-1:0]           mon_valid,
    output logic [N_TERM*PCKG_SZ-1:0]   mon_data,
    input  logic [N_TERM-1:0]           mon_ready,
    input  logic                        clr_stats,
    output logic [N_TERM*CNT_W-1:0]     tx_cnt,
    output logic [N_TERM*CNT_W-1:0]     rx_cnt,
    output logic [N_TERM-1:0]           tx_ovf,
    output logic [N_TERM-1:0]           tx_udf
);

    logic [N_TERM-1:0] tx_full, tx_empty, rx_full, rx_empty;
    logic              run_q;
    logic [CNT_W-1:0]  tx_cnt_q [N_TERM];
    logic [CNT_W-1:0]  tx_cnt_d [N_TERM];
    logic [CNT_W-1:0]  rx_cnt_q [N_TERM];
    logic [CNT_W-1:0]  rx_cnt_d [N_TERM];
    logic [N_TERM-1:0] tx_ovf_q, tx_ovf_d;
    logic [N_TERM-1:0] tx_udf_q, tx_udf_d;

    // Holds off mesh captures in the cycle following any reset edge.
    always_ff @(posedge clk) begin
        run_q <= !reset;
    end

    for (genvar i = 0; i < N_TERM; i++) begin : g_ch
        mesh_term_fifo #(.WIDTH(PCKG_SZ), .DEPTH(FIFO_DEPTH)) u_tx (
            .clk     (clk),
            .reset   (reset),
            .push_i  (drv_push[i]),
            .data_i  (drv_data[i*PCKG_SZ +: PCKG_SZ]),
            .pop_i   (popin[i]),
            .data_o  (data_out_i_in[i*PCKG_SZ +: PCKG_SZ]),
            .full_o  (tx_full[i]),
            .empty_o (tx_empty[i])
        );

        mesh_term_fifo #(.WIDTH(PCKG_SZ), .DEPTH(FIFO_DEPTH)) u_rx (
            .clk     (clk),
            .reset   (reset),
            .push_i  (pop[i]),
            .data_i  (data_out[i*PCKG_SZ +: PCKG_SZ]),
            .pop_i   (mon_ready[i]),
            .data_o  (mon_data[i*PCKG_SZ +: PCKG_SZ]),
            .full_o  (rx_full[i]),
            .empty_o (rx_empty[i])
        );

        assign pop[i] = run_q && !reset && pndng[i] && (!rx_full[i] || mon_ready[i]);

        assign tx_cnt[i*CNT_W +: CNT_W] = tx_cnt_q[i];
        assign rx_cnt[i*CNT_W +: CNT_W] = rx_cnt_q[i];
    end

    assign drv_full   = tx_full;
    assign pndng_i_in = ~tx_empty;
    assign mon_valid  = ~rx_empty;
    assign tx_ovf     = tx_ovf_q;
    assign tx_udf     = tx_udf_q;

    // Saturating per-channel counters and sticky error flags.
    always_comb begin
        tx_ovf_d = tx_ovf_q | (drv_push & tx_full & ~popin);
        tx_udf_d = tx_udf_q | (popin & tx_empty);
        for (int i = 0; i < int'(N_TERM); i++) begin
            tx_cnt_d[i] = tx_cnt_q[i];
            rx_cnt_d[i] = rx_cnt_q[i];
            if (popin[i] && !tx_empty[i] && (tx_cnt_q[i] != '1)) begin
                tx_cnt_d[i] = tx_cnt_q[i] + CNT_W'(1);
            end
            if (pop[i] && (rx_cnt_q[i] != '1)) begin
                rx_cnt_d[i] = rx_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_stats) begin
            tx_ovf_q <= '0;
            tx_udf_q <= '0;
            for (int i = 0; i < int'(N_TERM); i++) begin
                tx_cnt_q[i] <= '0;
                rx_cnt_q[i] <= '0;
            end
        end else begin
            tx_ovf_q <= tx_ovf_d;
            tx_udf_q <= tx_udf_d;
            for (int i = 0; i < int'(N_TERM); i++) begin
                tx_cnt_q[i] <= tx_cnt_d[i];
                rx_cnt_q[i] <= rx_cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mesh_term_fifo_bank.sv
// Directed bench for mesh_term_fifo_bank: default 4x4 instance plus a small 2-bit-counter instance.
module tb_mesh_term_fifo_bank;
    import mesh_term_pkg::*;

    localparam int unsigned N  = 16;
    localparam int unsigned W  = 40;
    localparam int unsigned C  = 16;
    localparam int unsigned N1 = 4;
    localparam int unsigned W1 = 8;
    localparam int unsigned C1 = 2;

    logic clk = 1'b0;
    logic reset, clr_stats;
    always #5 clk = ~clk;

    logic [N-1:0]   drv_push, drv_full, pndng_i_in, popin, pndng, pop, mon_valid, mon_ready, tx_ovf, tx_udf;
    logic [N*W-1:0] drv_data, data_out_i_in, data_out, mon_data;
    logic [N*C-1:0] tx_cnt, rx_cnt;

    logic [N1-1:0]    drv_push1, drv_full1, pndng_i_in1, popin1, pndng1, pop1, mon_valid1, mon_ready1, tx_ovf1, tx_udf1;
    logic [N1*W1-1:0] drv_data1, data_out_i_in1, data_out1, mon_data1;
    logic [N1*C1-1:0] tx_cnt1, rx_cnt1;

    int checks = 0;
    int errors = 0;

    mesh_term_fifo_bank u_dut (
        .clk(clk), .reset(reset),
        .drv_push(drv_push), .drv_data(drv_data), .drv_full(drv_full),
        .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in), .popin(popin),
        .pndng(pndng), .data_out(data_out), .pop(pop),
        .mon_valid(mon_valid), .mon_data(mon_data), .mon_ready(mon_ready),
        .clr_stats(clr_stats), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt),
        .tx_ovf(tx_ovf), .tx_udf(tx_udf)
    );

    mesh_term_fifo_bank #(.ROWS(1), .COLUMS(1), .PCKG_SZ(W1), .FIFO_DEPTH(4), .CNT_W(C1)) u_dut_small (
        .clk(clk), .reset(reset),
        .drv_push(drv_push1), .drv_data(drv_data1), .drv_full(drv_full1),
        .pndng_i_in(pndng_i_in1), .data_out_i_in(data_out_i_in1), .popin(popin1),
        .pndng(pndng1), .data_out(data_out1), .pop(pop1),
        .mon_valid(mon_valid1), .mon_data(mon_data1), .mon_ready(mon_ready1),
        .clr_stats(clr_stats), .tx_cnt(tx_cnt1), .rx_cnt(rx_cnt1),
        .tx_ovf(tx_ovf1), .tx_udf(tx_udf1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic pkt_t tx_head(input int i);
        return data_out_i_in[i*W +: W];
    endfunction

    function automatic pkt_t rx_head(input int i);
        return mon_data[i*W +: W];
    endfunction

    function automatic cnt_t txc(input int i);
        return tx_cnt[i*C +: C];
    endfunction

    function automatic cnt_t rxc(input int i);
        return rx_cnt[i*C +: C];
    endfunction

    initial begin
        int   pops;
        int   sent;
        logic pop_seen;

        reset = 1'b1; clr_stats = 1'b0;
        drv_push = '0; drv_data = '0; popin = '0; pndng = '1; data_out = '0; mon_ready = '0;
        drv_push1 = '0; drv_data1 = '0; popin1 = '0; pndng1 = '1; data_out1 = '0; mon_ready1 = '0;

        // Reset held for 10 cycles with the mesh offering everywhere.
        pop_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            pop_seen = pop_seen | (|pop) | (|pop1);
        end
        chk("reset_pop_never", 64'(pop_seen), 64'd0);
        chk("reset_drv_full", 64'(drv_full), 64'd0);
        chk("reset_pndng_i_in", 64'(pndng_i_in), 64'd0);
        chk("reset_mon_valid", 64'(mon_valid), 64'd0);
        chk("reset_data_zero", 64'((|data_out_i_in) | (|mon_data)), 64'd0);
        chk("reset_cnt_zero", 64'((|tx_cnt) | (|rx_cnt)), 64'd0);
        chk("reset_flags_zero", 64'({tx_ovf, tx_udf}), 64'd0);

        pndng = '0; pndng1 = '0; reset = 1'b0;
        step();

        // Channel 3: single packet round trip.
        drv_push[3] = 1'b1; drv_data[3*W +: W] = 40'hA5A5A5A5A5;
        step();
        drv_push[3] = 1'b0;
        chk("ch3_pndng_after_push", 64'(pndng_i_in[3]), 64'd1);
        chk("ch3_head", 64'(tx_head(3)), 64'hA5A5A5A5A5);
        popin[3] = 1'b1;
        step();
        popin[3] = 1'b0;
        chk("ch3_pndng_after_pop", 64'(pndng_i_in[3]), 64'd0);
        chk("ch3_tx_cnt", 64'(txc(3)), 64'd1);

        // Channel 0: overfill, then push+popin while full, then drain in order.
        drv_push[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drv_data[0 +: W] = 40'h1000 + 40'(k);
            step();
            if (k == 3) begin
                chk("ch0_full_after_4", 64'(drv_full[0]), 64'd1);
                chk("ch0_no_ovf_yet", 64'(tx_ovf[0]), 64'd0);
            end
        end
        chk("ch0_full_after_5", 64'(drv_full[0]), 64'd1);
        chk("ch0_ovf", 64'(tx_ovf[0]), 64'd1);
        chk("ch0_head_oldest", 64'(tx_head(0)), 64'h1000);
        drv_data[0 +: W] = 40'h2000; popin[0] = 1'b1;
        step();
        drv_push[0] = 1'b0;
        chk("ch0_full_after_pushpop", 64'(drv_full[0]), 64'd1);
        chk("ch0_head_after_pushpop", 64'(tx_head(0)), 64'h1001);
        step();
        chk("ch0_head_drain1", 64'(tx_head(0)), 64'h1002);
        chk("ch0_not_full", 64'(drv_full[0]), 64'd0);
        step();
        chk("ch0_head_drain2", 64'(tx_head(0)), 64'h1003);
        step();
        chk("ch0_head_drain3", 64'(tx_head(0)), 64'h2000);
        step();
        popin[0] = 1'b0;
        chk("ch0_empty", 64'(pndng_i_in[0]), 64'd0);
        chk("ch0_tx_cnt", 64'(txc(0)), 64'd5);

        // Channel 7: RX backpressure with the monitor stalled.
        pndng[7] = 1'b1; pops = 0; sent = 0;
        for (int k = 0; k < 6; k++) begin
            data_out[7*W +: W] = 40'h7000 + 40'(sent);
            #1;
            if (pop[7]) begin
                pops++;
                sent++;
                if (k >= 4) chk("ch7_pop_late", 64'(k), 64'd99);
            end
            step();
        end
        data_out[7*W +: W] = 40'h7000 + 40'(sent);
        #1;
        chk("ch7_pop_count", 64'(pops), 64'd4);
        chk("ch7_pop_held_low", 64'(pop[7]), 64'd0);
        chk("ch7_rx_cnt4", 64'(rxc(7)), 64'd4);
        chk("ch7_mon_head", 64'(rx_head(7)), 64'h7000);
        mon_ready[7] = 1'b1;
        #1;
        chk("ch7_pop_with_ready", 64'(pop[7]), 64'd1);
        step();
        mon_ready[7] = 1'b0; pndng[7] = 1'b0;
        chk("ch7_rx_cnt5", 64'(rxc(7)), 64'd5);
        mon_ready[7] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("ch7_drain_order", 64'(rx_head(7)), 64'h7000 + 64'(k));
            step();
        end
        mon_ready[7] = 1'b0;
        chk("ch7_drained", 64'(mon_valid[7]), 64'd0);

        // Channel 2 underflow; channel 5 keeps a packet across a stats clear.
        popin[2] = 1'b1; drv_push[5] = 1'b1; drv_data[5*W +: W] = 40'h55;
        step();
        popin[2] = 1'b0; drv_push[5] = 1'b0;
        chk("ch2_udf", 64'(tx_udf[2]), 64'd1);
        chk("ch2_tx_cnt", 64'(txc(2)), 64'd0);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        chk("clr_flags", 64'({tx_ovf, tx_udf}), 64'd0);
        chk("clr_cnts", 64'((|tx_cnt) | (|rx_cnt)), 64'd0);
        chk("clr_keeps_fifo", 64'(pndng_i_in[5]), 64'd1);
        chk("clr_keeps_head", 64'(tx_head(5)), 64'h55);

        // Small instance: 2-bit counter saturates.
        pndng1[1] = 1'b1; mon_ready1[1] = 1'b1; pops = 0;
        for (int k = 0; k < 5; k++) begin
            data_out1[1*W1 +: W1] = 8'(k);
            #1;
            if (pop1[1]) pops++;
            step();
        end
        pndng1[1] = 1'b0; mon_ready1[1] = 1'b0;
        chk("small_pops", 64'(pops), 64'd5);
        chk("small_rx_cnt_sat", 64'(rx_cnt1[1*C1 +: C1]), 64'd3);

        // Reset while several channels hold data.
        drv_push[9] = 1'b1; drv_data[9*W +: W] = 40'h99; pndng[7] = 1'b1;
        step();
        step();
        drv_push[9] = 1'b0;
        chk("pre_reset_ch9_full_half", 64'(pndng_i_in[9]), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("post_reset_pop_low", 64'(pop[7]), 64'd0);
        chk("post_reset_pndng_i_in", 64'(pndng_i_in), 64'd0);
        chk("post_reset_mon_valid", 64'(mon_valid), 64'd0);
        chk("post_reset_data", 64'((|data_out_i_in) | (|mon_data)), 64'd0);
        chk("post_reset_cnts", 64'((|tx_cnt) | (|rx_cnt)), 64'd0);
        step();
        chk("pop_resumes", 64'(pop[7]), 64'd1);
        pndng[7] = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mesh_term_fifo_bank.md
Name: mesh_term_fifo_bank

Overview:
- Parametrised terminal-side buffering bank for the ROWS x COLUMS mesh bus.
- One channel per mesh terminal; N_TERM = 2*ROWS + 2*COLUMS.
- Each channel has two FIFOs:
  - TX FIFO: driver → mesh, presented on pndng_i_in / data_out_i_in, drained by popin.
  - RX FIFO: mesh → monitor, filled by handshaking pndng / data_out with pop.
- New behaviour: per-channel packet counters, sticky overflow/underflow flags, synchronous statistics clear.

Parameters:
- ROWS, 4, mesh rows.
- COLUMS, 4, mesh columns.
- PCKG_SZ, 40, packet width in bits.
- FIFO_DEPTH, 4, entries per TX FIFO and per RX FIFO; any value ≥ 2, not required to be a power of 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- drv_push  in  N_TERM  push request into TX FIFO i.
- drv_data  in  N_TERM*PCKG_SZ  TX data; channel i at [i*PCKG_SZ +: PCKG_SZ].
- drv_full  out  N_TERM  TX FIFO i full.
- pndng_i_in  out  N_TERM  TX FIFO i non-empty, toward mesh.
- data_out_i_in  out  N_TERM*PCKG_SZ  TX FIFO i head, toward mesh.
- popin  in  N_TERM  mesh consumed TX head i.
- pndng  in  N_TERM  mesh has a packet for terminal i.
- data_out  in  N_TERM*PCKG_SZ  mesh packet for terminal i.
- pop  out  N_TERM  capture strobe toward mesh.
- mon_valid  out  N_TERM  RX FIFO i non-empty.
- mon_data  out  N_TERM*PCKG_SZ  RX FIFO i head.
- mon_ready  in  N_TERM  monitor consumes RX head i.
- clr_stats  in  1  synchronous clear of counters and flags.
- tx_cnt  out  N_TERM*CNT_W  packets accepted by mesh (popin on non-empty), per channel.
- rx_cnt  out  N_TERM*CNT_W  packets captured from mesh, per channel.
- tx_ovf  out  N_TERM  sticky: push dropped.
- tx_udf  out  N_TERM  sticky: popin while TX FIFO empty.

Behaviour:
- Reset values: all FIFOs empty; all flags 0; all counters 0. Hence drv_full=0, pndng_i_in=0, mon_valid=0, pop=0. data outputs are 0 after reset.
- Priority: reset > clr_stats > normal operation.
- clr_stats does not touch FIFO contents.
- Channels are fully independent; there is no cross-channel arbitration.

TX FIFO:
- First-word-fall-through.
- pndng_i_in[i] = (count != 0); data_out_i_in = head. Both are driven from registers or state, with no combinational path from popin.
- Write latency: a packet pushed at edge k is visible on pndng_i_in at the cycle after edge k.
- Push accepted iff drv_push && (!full || popin). Simultaneous push+popin on a full FIFO is accepted and count stays unchanged.
- A rejected push sets tx_ovf; the data is discarded.
- popin on an empty FIFO: ignored, sets tx_udf, tx_cnt unchanged.
- Pointers wrap at FIFO_DEPTH - 1 back to 0.
- drv_full = (count == FIFO_DEPTH).

RX FIFO:
- pop[i] = pndng[i] && (rx_count < FIFO_DEPTH || mon_ready[i]). This is combinational; it is the only combinational path.
- data_out is written on the same edge pop is high; rx_cnt increments on that edge.
- Backpressure: when the RX FIFO is full and mon_ready=0, pop stays low and the mesh packet is held. Nothing is ever dropped on RX.
- mon_valid / mon_data behave first-word-fall-through.
- mon_ready while empty is ignored.

Counters:
- Saturate at 2^CNT_W - 1; no wrap.

Reset mid-operation:
- All in-flight packets are discarded.
- pop and pndng_i_in are low in the cycle after the reset edge.

Decomposition:
- Package mesh_term_pkg:
  - function n_term(ROWS, COLUMS);
  - typedef pkt_t (logic [PCKG_SZ-1:0]), parametrised through a package-level localparam default of 40;
  - typedef cnt_t.
- Sub-module mesh_term_fifo: a parametrised synchronous FWFT FIFO (WIDTH, DEPTH) with push/pop/full/empty/count.
  - It is instantiated 2*N_TERM times via generate.
  - Counters and flags live in the top module.

Test Plan:
- Reset then idle 10 cycles → every output 0, pop never asserted even with pndng=all-ones.
- Channel 3: push 0xA5A5A5A5A5 at cycle 1 → pndng_i_in[3]=1 and data_out_i_in[3]=0xA5A5A5A5A5 at cycle 2; popin at cycle 3 → pndng_i_in[3]=0 at cycle 4, tx_cnt[3]=1.
- Channel 0: push 5 packets with FIFO_DEPTH=4 and no popin → drv_full[0]=1 after 4th push, 5th dropped, tx_ovf[0]=1. Then push+popin in the same cycle while full → accepted, count stays 4.
- Channel 7: pndng held high, mon_ready=0 → pop high for exactly 4 cycles then low, rx_cnt[7]=4. Then mon_ready=1 for one cycle → pop=1 that cycle, rx_cnt=5, mon_data shows packets in arrival order.
- popin on empty channel 2 → tx_udf[2]=1, tx_cnt[2]=0. clr_stats pulse → flags and counters 0, FIFO contents unchanged.
- CNT_W=2: capture 5 packets on channel 1 → rx_cnt[1] saturates at 3. Assert reset while channels are half-full → everything empty next cycle.
